// File: rtl/vrf_read_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vrf_read_scheduler_pkg
// Shared lane package for the VRF read scheduler. It holds the request field
// widths and the read-request struct used to carry one requester's fields
// through the arbiter mux.
// No ports (package).
// -----------------------------------------------------------------------------
package vrf_read_scheduler_pkg;

  localparam int VS_W    = 5;   // vector register index
  localparam int OFF_W   = 2;   // offset within register group
  localparam int RS_W    = 4;   // read source tag
  localparam int II_W    = 3;   // issuing instruction slot
  localparam int CNT_W   = 16;  // grant counter width

  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [OFF_W-1:0] offset;
    logic [RS_W-1:0]  read_source;
    logic [II_W-1:0]  instruction_index;
  } rd_req_t;

endpackage

// File: rtl/vrf_read_scheduler_rr_pointer_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pointer_arbiter
// Round-robin arbiter with a registered priority pointer. The pointer names
// the requester with highest priority; it moves to the one after the current
// winner only when the grant is actually consumed (fire).
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (pointer -> 0)
//   req        per-requester request vector
//   fire       grant consumed this cycle, advance pointer
//   grant      one-hot grant (zero when no request)
//   grant_idx  binary index of the granted requester
//   any        at least one request present
// -----------------------------------------------------------------------------
module rr_pointer_arbiter #(
  parameter int N = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N-1:0]                      req,
  input  logic                              fire,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic                              any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   scan;

  // Scan requesters starting at the pointer, wrapping past N-1 back to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) begin
        scan = scan - (IW+1)'(N);
      end
      if (!any && req[scan[IW-1:0]]) begin
        any                    = 1'b1;
        grant[scan[IW-1:0]]    = 1'b1;
        grant_idx              = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (fire) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vrf_read_scheduler.sv
// -----------------------------------------------------------------------------
// vrf_read_scheduler
// Arbitrates NREQ read requesters onto a single VRF read port (one grant per
// cycle, round-robin), tracks each accepted read through a LATENCY-deep
// pipeline and steers the returning data back to its requester as a one-hot
// response strobe.
// Ports:
//   clock, reset                 clock / async active-low reset
//   req_valid/req_ready          per-requester request handshake
//   req_vs/offset/readSource/instructionIndex   per-requester request fields
//   vrf_valid/vrf_ready          VRF port handshake (ready = no bank conflict)
//   vrf_vs/offset/readSource/instructionIndex   winning request fields
//   vrf_rdata                    read data, LATENCY cycles after acceptance
//   resp_valid/data/readSource   response to originating requester
//   flush                        drop everything in flight (and this cycle's read)
//   hold                         suppress new grants
//   busy                         any read in flight
//   grant_count                  saturating count of accepted reads
// -----------------------------------------------------------------------------
module vrf_read_scheduler
  import vrf_read_scheduler_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LATENCY = 2,
  parameter int DW      = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][VS_W-1:0]  req_vs,
  input  logic [NREQ-1:0][OFF_W-1:0] req_offset,
  input  logic [NREQ-1:0][RS_W-1:0]  req_readSource,
  input  logic [NREQ-1:0][II_W-1:0]  req_instructionIndex,
  output logic                       vrf_valid,
  input  logic                       vrf_ready,
  output logic [VS_W-1:0]            vrf_vs,
  output logic [OFF_W-1:0]           vrf_offset,
  output logic [RS_W-1:0]            vrf_readSource,
  output logic [II_W-1:0]            vrf_instructionIndex,
  input  logic [DW-1:0]              vrf_rdata,
  output logic [NREQ-1:0]            resp_valid,
  output logic [DW-1:0]              resp_data,
  output logic [RS_W-1:0]            resp_readSource,
  input  logic                       flush,
  input  logic                       hold,
  output logic                       busy,
  output logic [CNT_W-1:0]           grant_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rd_req_t [NREQ-1:0] reqs;
  rd_req_t            win;
  logic [NREQ-1:0]    grant;
  logic [IW-1:0]      win_idx;
  logic               any_req;
  logic               fire;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqs[i] = '{vs:                req_vs[i],
                  offset:            req_offset[i],
                  read_source:       req_readSource[i],
                  instruction_index: req_instructionIndex[i]};
    end
  end

  rr_pointer_arbiter #(.N(NREQ)) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .fire      (fire),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (any_req)
  );

  // hold masks the grant but not the arbitration, so the pointer is untouched.
  assign vrf_valid = any_req & ~hold;
  assign fire      = vrf_valid & vrf_ready;
  assign req_ready = (vrf_ready & ~hold) ? grant : '0;

  always_comb begin
    win = vrf_valid ? reqs[win_idx] : '0;
  end

  assign vrf_vs               = win.vs;
  assign vrf_offset           = win.offset;
  assign vrf_readSource       = win.read_source;
  assign vrf_instructionIndex = win.instruction_index;

  // Stage 0 .. LATENCY-1: tracking pipeline aligned with the VRF read latency.
  logic [LATENCY-1:0]           vld_q;
  logic [LATENCY-1:0][IW-1:0]   id_q;
  logic [LATENCY-1:0][RS_W-1:0] tag_q;
  logic [CNT_W-1:0]             grant_count_q;

  // A read accepted during a flush cycle is dropped but still counted and
  // still advances the pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= fire & ~flush;
      for (int s = 1; s < LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1] & ~flush;
      end
    end
  end

  always_ff @(posedge clock) begin
    id_q[0]  <= win_idx;
    tag_q[0] <= win.read_source;
    for (int s = 1; s < LATENCY; s++) begin
      id_q[s]  <= id_q[s-1];
      tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_count_q <= '0;
    end else if (fire) begin
      grant_count_q <= sat_inc(grant_count_q);
    end
  end

  // Pipeline exit: data comes straight from the VRF in the exit cycle.
  always_comb begin
    resp_valid      = '0;
    resp_data       = '0;
    resp_readSource = '0;
    if (vld_q[LATENCY-1]) begin
      resp_valid[id_q[LATENCY-1]] = 1'b1;
      resp_data                   = vrf_rdata;
      resp_readSource             = tag_q[LATENCY-1];
    end
  end

  assign busy        = |vld_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_vrf_read_scheduler.sv
module tb_vrf_read_scheduler;
  import vrf_read_scheduler_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int DW   = 32;

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][VS_W-1:0]  req_vs = '0;
  logic [NREQ-1:0][OFF_W-1:0] req_offset = '0;
  logic [NREQ-1:0][RS_W-1:0]  req_readSource = '0;
  logic [NREQ-1:0][II_W-1:0]  req_instructionIndex = '0;
  logic                       vrf_valid;
  logic                       vrf_ready = 1'b0;
  logic [VS_W-1:0]            vrf_vs;
  logic [OFF_W-1:0]           vrf_offset;
  logic [RS_W-1:0]            vrf_readSource;
  logic [II_W-1:0]            vrf_instructionIndex;
  logic [DW-1:0]              vrf_rdata = '0;
  logic [NREQ-1:0]            resp_valid;
  logic [DW-1:0]              resp_data;
  logic [RS_W-1:0]            resp_readSource;
  logic                       flush = 1'b0;
  logic                       hold = 1'b0;
  logic                       busy;
  logic [15:0]                grant_count;

  vrf_read_scheduler #(.NREQ(NREQ), .LATENCY(LAT), .DW(DW)) dut (
    .clock                (clock),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_vs               (req_vs),
    .req_offset           (req_offset),
    .req_readSource       (req_readSource),
    .req_instructionIndex (req_instructionIndex),
    .vrf_valid            (vrf_valid),
    .vrf_ready            (vrf_ready),
    .vrf_vs               (vrf_vs),
    .vrf_offset           (vrf_offset),
    .vrf_readSource       (vrf_readSource),
    .vrf_instructionIndex (vrf_instructionIndex),
    .vrf_rdata            (vrf_rdata),
    .resp_valid           (resp_valid),
    .resp_data            (resp_data),
    .resp_readSource      (resp_readSource),
    .flush                (flush),
    .hold                 (hold),
    .busy                 (busy),
    .grant_count          (grant_count)
  );

  typedef struct {
    int          due;
    int          id;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [31:0]     rdata_at[int];
  exp_t            mon_e;
  int              cyc = 0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              mptr = 0;
  int              mcnt = 0;
  bit              pend_flush = 0;
  int              force_rs = -1;
  bit              use_force_data = 0;
  logic [31:0]     force_data = '0;
  logic [NREQ-1:0] last_ready;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, either the oldest outstanding read is due now or the
  // response port must be idle.
  always @(negedge clock) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      chk("resp_valid", 64'(resp_valid), 64'(1 << mon_e.id));
      chk("resp_readSource", 64'(resp_readSource), 64'(mon_e.tag));
      chk("resp_data", 64'(resp_data), 64'(mon_e.data));
    end else begin
      chk("resp_idle", {resp_valid, resp_data, resp_readSource}, 64'd0);
    end
  end

  // One clock of stimulus plus reference-model update.
  task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic hld, input logic fl);
    int          w;
    int          idx;
    bit          exp_vv;
    logic [31:0] d;
    @(posedge clock);
    #1;
    if (pend_flush) begin
      exp_q.delete();
      pend_flush = 0;
    end
    chk("grant_count", 64'(grant_count), 64'(mcnt));
    chk("busy", 64'(busy), 64'(exp_q.size() > 0));
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_vs[i]               = VS_W'($urandom);
      req_offset[i]           = OFF_W'($urandom);
      req_readSource[i]       = (force_rs >= 0) ? RS_W'(force_rs) : RS_W'($urandom);
      req_instructionIndex[i] = II_W'($urandom);
    end
    vrf_ready = rdy;
    hold      = hld;
    flush     = fl;
    if (rdata_at.exists(cyc)) begin
      vrf_rdata = rdata_at[cyc];
      rdata_at.delete(cyc);
    end else begin
      vrf_rdata = $urandom;
    end
    #1;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (w < 0 && v[idx]) w = idx;
    end
    exp_vv = (w >= 0) && !hld;
    chk("vrf_valid", 64'(vrf_valid), 64'(exp_vv));
    chk("req_ready", 64'(req_ready), (exp_vv && rdy) ? 64'(1 << w) : 64'd0);
    chk("vrf_fields", {vrf_vs, vrf_offset, vrf_readSource, vrf_instructionIndex},
        exp_vv ? {req_vs[w], req_offset[w], req_readSource[w], req_instructionIndex[w]} : 64'd0);
    if (exp_vv && rdy) begin
      mptr = (w + 1) % NREQ;
      if (mcnt < 65535) mcnt++;
      if (!fl) begin
        d = use_force_data ? force_data : $urandom;
        rdata_at[cyc + LAT] = d;
        exp_q.push_back('{cyc + LAT, w, req_readSource[w], d});
      end
    end
    if (fl) pend_flush = 1;
    last_ready = req_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    rdata_at.delete();
    mptr = 0;
    mcnt = 0;
    pend_flush = 0;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_grant_count", 64'(grant_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = 4'b1100;
    vrf_ready = 1'b1;
    hold      = 1'b0;
    flush     = 1'b0;
    #1;
    chk("rst_comb_req_ready", 64'(req_ready), 64'h4);
    chk("rst_comb_vrf_valid", 64'(vrf_valid), 64'd1);
    repeat (2) @(posedge clock);
    #1;
    req_valid = '0;
    reset     = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // All requesters active: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0, 1'b0);
      chk("rotate_accept", 64'(last_ready), 64'(1 << (i % 4)));
    end
    idle(LAT + 2);

    // Stalled port: no acceptance and no pointer movement.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1'b0, 1'b0, 1'b0);
      chk("stall_ready", 64'(last_ready), 64'd0);
    end
    step(4'b0110, 1'b1, 1'b0, 1'b0);
    chk("stall_first", 64'(last_ready), 64'h2);
    step(4'b0110, 1'b1, 1'b0, 1'b0);
    chk("stall_second", 64'(last_ready), 64'h4);
    idle(1);
    chk("stall_count", 64'(grant_count), 64'd2);
    idle(LAT + 1);

    // Single tagged read with known data at exit.
    do_reset();
    force_rs = 4'hA;
    force_data = 32'h1234_5678;
    use_force_data = 1;
    step(4'b0100, 1'b1, 1'b0, 1'b0);
    chk("tag_accept", 64'(last_ready), 64'h4);
    force_rs = -1;
    use_force_data = 0;
    idle(LAT);
    chk("tag_resp_valid", 64'(resp_valid), 64'h4);
    chk("tag_resp_rs", 64'(resp_readSource), 64'hA);
    chk("tag_resp_data", 64'(resp_data), 64'h1234_5678);
    idle(2);

    // Flush with reads in flight, including one accepted in the flush cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0, 1'b1);
    chk("flush_cycle_accept", 64'(last_ready), 64'h8);
    idle(1);
    chk("flush_busy", 64'(busy), 64'd0);
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    chk("flush_next_grant", 64'(last_ready), 64'h1);
    idle(LAT + 2);

    // hold: no grant, pointer frozen, resumes at the same priority.
    do_reset();
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, 1'b1, 1'b0);
      chk("hold_ready", 64'(last_ready), 64'd0);
    end
    step(4'b1111, 1'b1, 1'b0, 1'b0);
    chk("hold_resume", 64'(last_ready), 64'h2);
    idle(LAT + 2);

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0));
    end
    idle(LAT + 2);

    // Counter saturation with a single requester at full throughput.
    do_reset();
    for (int i = 0; i < 65537; i++) step(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("sat_count", 64'(grant_count), 64'hFFFF);

    // Reset in the middle of traffic discards in-flight reads.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle(LAT + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
